// File: rtl/dest_fifo_pause.sv
// Destination end of the VC->D link: routes pushed words by destination bit into
// two FIFOs, serves registered reads and drives hysteretic pause backpressure.
module dest_fifo_lane #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  vld,
  output logic                  pause,
  output logic                  empty,
  output logic                  full,
  output logic                  err
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count, count_nxt;
  logic                  wr_ok, rd_ok;

  // Acceptance uses pre-edge occupancy only: a same-cycle pop never frees a slot for a push.
  assign wr_ok = wr && (count < DEPTH_C);
  assign rd_ok = rd && (count != '0);
  assign err   = (wr && !wr_ok) || (rd && !rd_ok);
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      vld    <= 1'b0;
      pause  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      vld   <= rd_ok;
      count <= count_nxt;
      // Pause follows next occupancy so it rises on the edge that reaches AF_THRESH.
      if (count_nxt >= AF_C)      pause <= 1'b1;
      else if (count_nxt <= AE_C) pause <= 1'b0;
    end
  end
endmodule

module dest_fifo_pause #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop_d0,
  input  logic                  pop_d1,
  output logic [DATA_WIDTH-1:0] data_out_d0,
  output logic [DATA_WIDTH-1:0] data_out_d1,
  output logic                  valid_out_d0,
  output logic                  valid_out_d1,
  output logic                  d0_pause,
  output logic                  d1_pause,
  output logic                  d0_empty,
  output logic                  d1_empty,
  output logic                  d0_full,
  output logic                  d1_full,
  output logic                  error
);
  localparam int NUM_DST = 2;

  logic                               dst;
  logic [NUM_DST-1:0]                 wr, rd, vld, pause, empty, full, err;
  logic [NUM_DST-1:0][DATA_WIDTH-1:0] dout;

  assign dst = data_in[DATA_WIDTH-2];
  assign wr  = {push && dst, push && !dst};
  assign rd  = {pop_d1, pop_d0};

  for (genvar g = 0; g < NUM_DST; g++) begin : g_dst
    dest_fifo_lane #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .AF_THRESH(AF_THRESH),   .AE_THRESH(AE_THRESH)
    ) u_lane (
      .clk(clk), .reset_L(reset_L),
      .wr(wr[g]), .din(data_in), .rd(rd[g]),
      .dout(dout[g]), .vld(vld[g]), .pause(pause[g]),
      .empty(empty[g]), .full(full[g]), .err(err[g])
    );
  end

  assign data_out_d0  = dout[0];
  assign data_out_d1  = dout[1];
  assign valid_out_d0 = vld[0];
  assign valid_out_d1 = vld[1];
  assign d0_pause     = pause[0];
  assign d1_pause     = pause[1];
  assign d0_empty     = empty[0];
  assign d1_empty     = empty[1];
  assign d0_full      = full[0];
  assign d1_full      = full[1];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)  error <= 1'b0;
    else if (|err) error <= 1'b1;
  end
endmodule

// File: tb/tb_dest_fifo_pause.sv
// Directed bench for dest_fifo_pause: routing, hysteresis, overflow, wrap, underflow, async reset.
module tb_dest_fifo_pause;
  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [5:0] data_in = '0;
  logic       push = 1'b0, pop_d0 = 1'b0, pop_d1 = 1'b0;
  logic [5:0] data_out_d0, data_out_d1;
  logic       valid_out_d0, valid_out_d1, d0_pause, d1_pause;
  logic       d0_empty, d1_empty, d0_full, d1_full, error;
  int         n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  dest_fifo_pause dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .push(push),
    .pop_d0(pop_d0), .pop_d1(pop_d1),
    .data_out_d0(data_out_d0), .data_out_d1(data_out_d1),
    .valid_out_d0(valid_out_d0), .valid_out_d1(valid_out_d1),
    .d0_pause(d0_pause), .d1_pause(d1_pause),
    .d0_empty(d0_empty), .d1_empty(d1_empty),
    .d0_full(d0_full), .d1_full(d1_full), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge with inputs idle.
  task automatic cyc(input logic p, input logic [5:0] d, input logic p0, input logic p1);
    push = p; data_in = d; pop_d0 = p0; pop_d1 = p1;
    @(posedge clk); #1;
    push = 1'b0; pop_d0 = 1'b0; pop_d1 = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_L = 1'b0;
    #2 reset_L = 1'b1;
  endtask

  initial begin
    logic [5:0] q[$];
    logic [5:0] e;

    // reset state
    #12;
    chk("rst_e0", d0_empty, 1); chk("rst_e1", d1_empty, 1);
    chk("rst_f0", d0_full, 0);  chk("rst_p0", d0_pause, 0);
    chk("rst_err", error, 0);   chk("rst_v0", valid_out_d0, 0);
    chk("rst_do0", data_out_d0, 0);
    reset_L = 1'b1;
    @(posedge clk); #1;

    // routing by destination bit
    cyc(1, 6'b001010, 0, 0);
    chk("rt_e0", d0_empty, 0); chk("rt_e1a", d1_empty, 1);
    cyc(1, 6'b010101, 0, 0);
    chk("rt_e1b", d1_empty, 0);
    cyc(0, '0, 1, 1);
    chk("rt_do0", data_out_d0, 6'b001010); chk("rt_v0", valid_out_d0, 1);
    chk("rt_do1", data_out_d1, 6'b010101); chk("rt_v1", valid_out_d1, 1);
    chk("rt_emp0", d0_empty, 1);           chk("rt_emp1", d1_empty, 1);
    cyc(0, '0, 0, 0);
    chk("rt_v0_pulse", valid_out_d0, 0);

    // pause hysteresis on D0
    cyc(1, 6'h01, 0, 0); cyc(1, 6'h02, 0, 0);
    chk("ph_p_cnt2", d0_pause, 0);
    cyc(1, 6'h03, 0, 0);
    chk("ph_p_cnt3", d0_pause, 1); chk("ph_p1_a", d1_pause, 0);
    cyc(0, '0, 1, 0);
    chk("ph_hold", d0_pause, 1);   chk("ph_d", data_out_d0, 6'h01);
    cyc(0, '0, 1, 0);
    chk("ph_clear", d0_pause, 0);  chk("ph_d2", data_out_d0, 6'h02);
    chk("ph_p1_b", d1_pause, 0);
    cyc(0, '0, 1, 0);
    chk("ph_empty", d0_empty, 1);  chk("ph_err", error, 0);

    // overflow: 5th push is dropped
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 6'(i), 0, 0);
      if (i == 4) begin
        chk("ov_full4", d0_full, 1); chk("ov_err4", error, 0);
      end
    end
    chk("ov_err5", error, 1); chk("ov_full5", d0_full, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, '0, 1, 0);
      chk("ov_drain", data_out_d0, 6'(i));
    end
    chk("ov_empty", d0_empty, 1);
    cyc(0, '0, 0, 0);
    chk("ov_err_sticky", error, 1);

    // simultaneous push+pop at count 2 across pointer wrap
    cyc(1, 6'h0A, 0, 0); q.push_back(6'h0A);
    cyc(1, 6'h0B, 0, 0); q.push_back(6'h0B);
    for (int i = 0; i < 8; i++) begin
      q.push_back(6'h20 | 6'(i));
      cyc(1, 6'h20 | 6'(i), 1, 0);
      e = q.pop_front();
      chk("sp_data", data_out_d0, e); chk("sp_vld", valid_out_d0, 1);
      chk("sp_e", d0_empty, 0);       chk("sp_f", d0_full, 0);
    end
    cyc(0, '0, 0, 0);
    chk("sp_vld_off", valid_out_d0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, '0, 1, 0);
      e = q.pop_front();
      chk("sp_tail", data_out_d0, e);
    end
    chk("sp_empty", d0_empty, 1);

    // underflow on D1
    do_reset();
    @(posedge clk); #1;
    chk("uf_err0", error, 0);
    cyc(0, '0, 0, 1);
    chk("uf_vld", valid_out_d1, 0); chk("uf_err", error, 1);
    chk("uf_hold", data_out_d1, 0);
    cyc(0, '0, 0, 0); cyc(1, 6'h11, 0, 0);
    chk("uf_sticky", error, 1);

    // async reset between edges
    do_reset();
    cyc(1, 6'h01, 0, 0); cyc(1, 6'h02, 0, 0); cyc(1, 6'h03, 1, 0);
    cyc(1, 6'h04, 0, 0);
    chk("ar_pause_pre", d0_pause, 1); chk("ar_err_pre", error, 0);
    cyc(0, '0, 0, 1);
    chk("ar_err_uf", error, 1);
    push = 1'b1; data_in = 6'h05; pop_d0 = 1'b1;
    cyc(1, 6'h05, 1, 0);
    chk("ar_vld_pre", valid_out_d0, 1);
    #2 reset_L = 1'b0;
    #1;
    chk("ar_empty", d0_empty, 1); chk("ar_pause", d0_pause, 0);
    chk("ar_err", error, 0);      chk("ar_v0", valid_out_d0, 0);
    chk("ar_v1", valid_out_d1, 0);
    #2 reset_L = 1'b1;
    cyc(1, 6'h07, 0, 0);
    chk("ar_push_e", d0_empty, 0);
    cyc(0, '0, 1, 0);
    chk("ar_pop_d", data_out_d0, 6'h07); chk("ar_pop_v", valid_out_d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
